// File: rtl/ctr_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ctr_rr_arbiter
//
// Round-robin arbiter in front of a shared modulo-MOD counter. One requester
// at a time owns the counter for up to BURST consecutive cycles and may
// increment or clear it. Commands from every other requester are ignored.
//
// Ports
//   clk    in   1     clock, rising edge
//   reset  in   1     asynchronous reset, active-high
//   req    in   NREQ  per-requester ownership request (level)
//   inc    in   NREQ  per-requester increment command (owner's bit only)
//   clr    in   NREQ  per-requester clear command (owner's bit only, wins over inc)
//   gnt    out  NREQ  one-hot grant, registered; zero when idle
//   busy   out  1     OR of gnt
//   out    out  W     shared counter value, registered
//   wrap   out  1     one-cycle pulse when out goes MOD-1 -> 0 by increment
// ---------------------------------------------------------------------------
module ctr_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int MOD   = 3,
    parameter int W     = 2,
    parameter int BURST = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] inc,
    input  logic [NREQ-1:0] clr,
    output logic [NREQ-1:0] gnt,
    output logic            busy,
    output logic [W-1:0]    out,
    output logic            wrap
);

    localparam int IW = $clog2(NREQ);
    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

    localparam logic [W-1:0]    CNT_TOP    = W'(MOD - 1);
    localparam logic [BW-1:0]   BURST_LAST = BW'(BURST - 1);
    localparam logic [IW-1:0]   IDX_LAST   = IW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE_HOT0   = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] owner;
    logic [BW-1:0] bcnt;

    logic [IW-1:0] owner_next;
    logic [IW-1:0] search_base;
    logic [IW-1:0] pick;
    logic          pick_found;
    logic          release_now;
    logic          owner_inc;
    logic          owner_clr;

    // Arbitration and release decision. When a release happens the pointer
    // becomes owner+1, and the search must use that new pointer on the same
    // edge, so the search base is owner+1 whenever a grant is active.
    always_comb begin
        // NOTE: every signal gets a default before any conditional logic so
        // no path leaves it unassigned and no latch is inferred.
        owner_next  = (owner == IDX_LAST) ? '0 : owner + 1'b1;
        release_now = !req[owner] || (bcnt == BURST_LAST);
        owner_inc   = inc[owner];
        owner_clr   = clr[owner];
        search_base = (state == OWNED) ? owner_next : ptr;
        pick        = '0;
        pick_found  = 1'b0;
        // Walk from the farthest offset down to offset 0 so the nearest
        // requester above the base is the last (and winning) assignment.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[(int'(search_base) + i) % NREQ]) begin
                pick       = IW'((int'(search_base) + i) % NREQ);
                pick_found = 1'b1;
            end
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
            bcnt  <= '0;
            gnt   <= '0;
            out   <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            case (state)
                IDLE: begin
                    // Commands are ignored here; out holds.
                    if (pick_found) begin
                        state <= OWNED;
                        owner <= pick;
                        bcnt  <= '0;
                        gnt   <= ONE_HOT0 << pick;
                    end
                end

                OWNED: begin
                    // Owner's command is applied on every owned edge,
                    // including the one on which ownership is released.
                    if (owner_clr) begin
                        out <= '0;
                    end else if (owner_inc) begin
                        if (out == CNT_TOP) begin
                            out  <= '0;
                            wrap <= 1'b1;
                        end else begin
                            out <= out + 1'b1;
                        end
                    end

                    if (release_now) begin
                        ptr  <= owner_next;
                        bcnt <= '0;
                        if (pick_found) begin
                            // Handover (or regrant of a sole requester
                            // that exhausted its burst) with no idle cycle.
                            owner <= pick;
                            gnt   <= ONE_HOT0 << pick;
                        end else begin
                            state <= IDLE;
                            gnt   <= '0;
                        end
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

    assign busy = |gnt;

endmodule

// File: tb/tb_ctr_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ctr_rr_arbiter
//
// Directed bench for ctr_rr_arbiter (NREQ=4, MOD=3, W=2, BURST=4).
// Each stimulus step pushes the hand-computed outputs expected after the
// next rising edge, tagged with that edge's number; a monitor on the falling
// edge pops every entry due for the current edge and compares.
// ---------------------------------------------------------------------------
module tb_ctr_rr_arbiter;

    localparam int NREQ  = 4;
    localparam int MOD   = 3;
    localparam int W     = 2;
    localparam int BURST = 4;

    logic            clk;
    logic            reset;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] inc;
    logic [NREQ-1:0] clr;
    logic [NREQ-1:0] gnt;
    logic            busy;
    logic [W-1:0]    out;
    logic            wrap;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int              tag;
        logic [NREQ-1:0] gnt;
        logic [W-1:0]    out;
        logic            wrap;
        string           name;
    } exp_t;

    exp_t sb[$];

    ctr_rr_arbiter #(
        .NREQ (NREQ),
        .MOD  (MOD),
        .W    (W),
        .BURST(BURST)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .req  (req),
        .inc  (inc),
        .clr  (clr),
        .gnt  (gnt),
        .busy (busy),
        .out  (out),
        .wrap (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(input logic [NREQ-1:0] r, input logic [NREQ-1:0] i,
                        input logic [NREQ-1:0] c, input logic [NREQ-1:0] eg,
                        input logic [W-1:0] eo, input logic ew, input string nm);
        exp_t e;
        req = r;
        inc = i;
        clr = c;
        e.tag  = cyc + 1;
        e.gnt  = eg;
        e.out  = eo;
        e.wrap = ew;
        e.name = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares everything due at the current edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].tag <= cyc) begin
                e = sb.pop_front();
                if (e.tag < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL %s: stale entry for edge %0d seen at edge %0d", e.name, e.tag, cyc);
                end else begin
                    check({e.name, ".gnt"},  32'(gnt),  32'(e.gnt));
                    check({e.name, ".busy"}, 32'(busy), 32'(|e.gnt));
                    check({e.name, ".out"},  32'(out),  32'(e.out));
                    check({e.name, ".wrap"}, 32'(wrap), 32'(e.wrap));
                end
            end
        end
    end

    initial begin
        logic [NREQ-1:0] eg;
        logic [W-1:0]    eo;
        logic            ew;
        int              wait_cycles;

        reset = 1'b1;
        req   = '0;
        inc   = '0;
        clr   = '0;
        #1;
        check("reset0.gnt",  32'(gnt),  32'h0);
        check("reset0.busy", 32'(busy), 32'h0);
        check("reset0.out",  32'(out),  32'h0);
        check("reset0.wrap", 32'(wrap), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single requester: grant latency, count 1,2,0,1 with wrap, regrant.
        step(4'b0001, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0, "single_grant");
        step(4'b0001, 4'b0001, 4'b0000, 4'b0001, 2'd1, 1'b0, "single_c1");
        step(4'b0001, 4'b0001, 4'b0000, 4'b0001, 2'd2, 1'b0, "single_c2");
        step(4'b0001, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, "single_wrap");
        step(4'b0001, 4'b0001, 4'b0000, 4'b0001, 2'd1, 1'b0, "single_regrant");
        // Clear priority with out=2.
        step(4'b0001, 4'b0001, 4'b0000, 4'b0001, 2'd2, 1'b0, "clr_setup");
        step(4'b0001, 4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b0, "clr_priority");
        // Drop request -> idle; commands in idle ignored.
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, "drop_idle");
        step(4'b0000, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0, "idle_inc_ignored");
        // Pointer is now 1; owner 1 while requester 3 issues commands.
        step(4'b0010, 4'b0000, 4'b0000, 4'b0010, 2'd0, 1'b0, "own1_grant");
        step(4'b0010, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0, "own1_inc");
        step(4'b1010, 4'b1000, 4'b1000, 4'b0010, 2'd1, 1'b0, "nonowner_ignored");
        step(4'b0010, 4'b0010, 4'b0000, 4'b0010, 2'd2, 1'b0, "own1_inc2");
        step(4'b0010, 4'b0000, 4'b0000, 4'b0010, 2'd2, 1'b0, "own1_regrant");
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, "own1_release");
        step(4'b0100, 4'b0000, 4'b0000, 4'b0100, 2'd2, 1'b0, "own2_grant");

        // Asynchronous reset mid-cycle with out=2, gnt=0100.
        @(negedge clk);
        #1;
        reset = 1'b1;
        req   = '0;
        inc   = '0;
        clr   = '0;
        #1;
        check("async_reset.gnt",  32'(gnt),  32'h0);
        check("async_reset.busy", 32'(busy), 32'h0);
        check("async_reset.out",  32'(out),  32'h0);
        check("async_reset.wrap", 32'(wrap), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Fairness: all request and increment; 4 cycles per owner, no gaps.
        for (int k = 1; k <= 17; k++) begin
            eg = 4'b0001 << (((k - 1) / BURST) % NREQ);
            eo = (k == 1) ? 2'd0 : W'((k - 1) % MOD);
            ew = (k >= 2) && (((k - 1) % MOD) == 0);
            step(4'b1111, 4'b1111, 4'b0000, eg, eo, ew, $sformatf("rr_%0d", k));
        end

        // Owner 0 drops request -> owner 2; owner 2 drops after one cycle
        // with requester 0 waiting; its final increment wraps the counter.
        step(4'b0100, 4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b0, "early_to2");
        step(4'b0001, 4'b0100, 4'b0000, 4'b0001, 2'd0, 1'b1, "early_2to0");
        step(4'b0000, 4'b0001, 4'b0000, 4'b0000, 2'd1, 1'b0, "final_inc_idle");
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, "idle_hold");

        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctr_rr_arbiter.md
Name: ctr_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one modulo-MOD counter among NREQ requesters.
- A granted requester owns the counter for up to BURST cycles and may increment or clear it; all other requesters' commands are ignored.
- Sits in front of the counter datapath, so several control units can drive one counter without conflicts.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MOD, 3, counter modulus: counts 0..MOD-1, then wraps to 0 (2 <= MOD <= 2^W).
- W, 2, counter width in bits.
- BURST, 4, maximum consecutive owned cycles per grant (>= 1).

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous reset, active-high.
- Req  in  NREQ  per-requester ownership request, level.
- Inc  in  NREQ  per-requester increment command; only the owner's bit is used.
- Clr  in  NREQ  per-requester clear command; only the owner's bit is used.
- Gnt  out  NREQ  one-hot grant, registered; all zero when idle.
- Busy  out  1  high while any grant is active (equals OR of Gnt).
- Out  out  W  shared counter value, registered.
- Wrap  out  1  one-cycle pulse on the edge where Out goes from MOD-1 to 0 by increment.

Behaviour:
- Reset (asynchronous, immediate): Gnt=0, Busy=0, Out=0, Wrap=0, round-robin pointer=0, burst count=0, state IDLE. Applies mid-burst too; the counter value is lost.
- States:
  - IDLE: no owner.
  - OWNED: owner o; Gnt[o]=1.
- Arbitration: select the first i with Req[i]=1, searching from the pointer upward and wrapping modulo NREQ.
- IDLE -> OWNED: arbitration runs on the edge where Req is sampled. Gnt is high after that edge (latency 1 cycle). Burst count resets to 0.
- Inc/Clr during IDLE: ignored; Out holds.
- OWNED, every edge, counter update from the owner's bits:
  - Clr[o]=1: Out<=0, Wrap=0. Clr has priority over Inc.
  - Else Inc[o]=1: if Out==MOD-1 then Out<=0 and Wrap=1; otherwise Out<=Out+1.
  - Else: Out holds.
- Command timing: commands are sampled on every edge where Gnt[o]=1, including the releasing edge. Non-owner Inc/Clr bits never affect Out.
- Release condition at an edge: Req[o]==0, or burst count==BURST-1.
  - On release, pointer<=o+1 mod NREQ and arbitration reruns on the same edge.
  - If any Req is found (excluding o when o released by dropping Req), the new owner is granted with no idle bubble.
  - If o exhausted its burst and is the only requester, o is regranted with burst count 0.
  - If nothing is found: go to IDLE, Gnt=0.
- No release: burst count increments; Gnt holds.
- Pointer moves only on release; a requester that keeps Req high stays owner for BURST cycles.
- Gnt is always one-hot or zero. Busy equals OR of Gnt.
- Wrap is high for exactly one cycle per wrap and low in every other cycle.
- Width rule: increment is modulo MOD, never modulo 2^W.

Test Plan:
- Reset: assert Reset mid-cycle with Out=2 and Gnt=0100 -> outputs zero immediately, without waiting for a Clk edge.
- Single requester: Req=0001, Inc=0001 held for 4 cycles (MOD=3) -> Gnt=0001 one cycle after Req. Out sequence 1,2,0,1; Wrap pulses on the 2->0 edge. After 4 owned cycles, requester 0 is regranted with no gap.
- Clear priority: owner asserts Inc and Clr together with Out=2 -> Out=0, Wrap=0.
- Ignore non-owner: Gnt=0010; requester 3 drives Inc=1000 and Clr=1000 -> Out unchanged.
- Round-robin fairness: Req=1111 held continuously, BURST=4 -> grants 0001, 0010, 0100, 1000, 0001, each for exactly 4 cycles, with no idle cycle between grants.
- Early release: owner 2 drops Req after 1 cycle while Req[0]=1 -> Gnt goes 0100 to 0001 on the same edge. Owner 2's Inc in its final owned cycle is applied.
